// File: rtl/link_pkg.sv
// Shared definitions for the link order path (link_top and link_order_queue).
// Order type encodings, default field widths and the packed order record.
package link_pkg;

  localparam logic [1:0] APPE = 2'b00;
  localparam logic [1:0] DELE = 2'b01;
  localparam logic [1:0] CHAG = 2'b10;
  localparam logic [1:0] READ = 2'b11;

  localparam int LINK_ADDR_W  = 16;
  localparam int LINK_DATA_W  = 16;
  localparam int LINK_TABLE_W = 8;

  // Packed order as carried through the queue: {type, table, node, data}.
  // Modules with non-default widths carry the same layout as a flat vector.
  typedef struct packed {
    logic [1:0]              otype;
    logic [LINK_TABLE_W-1:0] otable;
    logic [LINK_ADDR_W-1:0]  onode;
    logic [LINK_DATA_W-1:0]  odata;
  } order_t;

  // Head register occupancy as seen from the link_top side.
  typedef enum logic [1:0] {
    H_EMPTY   = 2'd0,
    H_PRESENT = 2'd1,
    H_STALL   = 2'd2
  } head_state_e;

  // Flat width of an order record for arbitrary field widths.
  function automatic int order_width(input int tw, input int aw, input int dw);
    return 2 + tw + aw + dw;
  endfunction

endpackage

// File: rtl/link_sync_fifo.sv
// Single-clock FIFO, DEPTH x WIDTH, valid/busy handshake on both sides.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Storage is deliberately not reset; only the pointers are.
module link_sync_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_busy,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_busy,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign wr_busy  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_valid = (wr_ptr_q != rd_ptr_q);
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en    = wr_valid & ~wr_busy;
  assign rd_en    = rd_valid & ~rd_busy;

  // Advance pointers on accepted writes and reads.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; no reset so it maps onto plain RAM/flop arrays.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/link_order_queue.sv
// Order queue in front of link_top. Buffers host orders and issues them
// strictly in order, holding back a READ head while MAX_RD_OUT READs are
// still waiting for their dout beat (tracked by snooping dout handshake).
// Optional: define LINK_ORDER_STAT_EN to add saturating per-type issue counters.
//
// Head state | meaning
// -----------+---------------------------------------------------------
// H_EMPTY    | no order in the output register, order_valid=0
// H_PRESENT  | order in the output register, offered with order_valid=1
// H_STALL    | READ in the output register, withheld until rd_out drops
//
// The output register counts toward level. A push into an empty queue (or
// into a queue whose only entry is leaving) bypasses the FIFO straight into
// the output register so it is offered on the next cycle.
module link_order_queue
  import link_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int TABLE_WIDTH = 8,
  parameter int DEPTH       = 8,
  parameter int MAX_RD_OUT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_busy,
  input  logic [1:0]                    in_type,
  input  logic [TABLE_WIDTH-1:0]        in_table,
  input  logic [ADDR_WIDTH-1:0]         in_node,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          order_valid,
  input  logic                          order_busy,
  output logic [1:0]                    order_type,
  output logic [TABLE_WIDTH-1:0]        order_table,
  output logic [ADDR_WIDTH-1:0]         order_node,
  output logic [DATA_WIDTH-1:0]         order_data,
  input  logic                          dout_valid,
  input  logic                          dout_busy,
  output logic [$clog2(DEPTH):0]        level,
  output logic [$clog2(MAX_RD_OUT):0]   rd_out
`ifdef LINK_ORDER_STAT_EN
  ,
  output logic [15:0]                   stat_appe,
  output logic [15:0]                   stat_dele,
  output logic [15:0]                   stat_chag,
  output logic [15:0]                   stat_read
`endif
);

  localparam int OW = order_width(TABLE_WIDTH, ADDR_WIDTH, DATA_WIDTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(MAX_RD_OUT) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [RW-1:0] MAX_L   = RW'(MAX_RD_OUT);

  head_state_e   head_state_q, head_state_d;
  logic          order_valid_q, order_valid_d;
  logic [OW-1:0] head_word_q, head_word_d;
  logic [LW-1:0] level_q, level_d;
  logic [RW-1:0] rd_out_q, rd_out_d;
  logic          in_busy_q, in_busy_d;

  logic [OW-1:0] in_word;
  logic [OW-1:0] load_word;
  logic [1:0]    head_type;
  logic          push;
  logic          xfer;
  logic          rd_inc;
  logic          rd_dec;
  logic          load;
  logic          take_in;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_wr_busy;
  logic          fifo_rd_valid;
  logic [OW-1:0] fifo_rd_data;

  assign in_word   = {in_type, in_table, in_node, in_data};
  assign head_type = head_word_q[OW-1 -: 2];
  assign push      = in_valid & ~in_busy_q;
  assign xfer      = order_valid_q & ~order_busy;
  assign rd_inc    = xfer & (head_type == READ);
  assign rd_dec    = dout_valid & ~dout_busy & (rd_out_q != '0);

  link_sync_fifo #(
    .WIDTH (OW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (fifo_push),
    .wr_busy  (fifo_wr_busy),
    .wr_data  (in_word),
    .rd_valid (fifo_rd_valid),
    .rd_busy  (~fifo_pop),
    .rd_data  (fifo_rd_data)
  );

  // Outstanding-READ tracker; a dout beat with nothing outstanding is dropped.
  always_comb begin
    rd_out_d = rd_out_q;
    if (rd_inc && !rd_dec)      rd_out_d = rd_out_q + RW'(1);
    else if (!rd_inc && rd_dec) rd_out_d = rd_out_q - RW'(1);
  end

  // Occupancy including the output register; full flag registered from it.
  always_comb begin
    level_d   = level_q + LW'(push) - LW'(xfer);
    in_busy_d = (level_d == DEPTH_L);
  end

  // Head next-state: choose what (if anything) lands in the output register.
  always_comb begin
    head_state_d  = head_state_q;
    order_valid_d = order_valid_q;
    head_word_d   = head_word_q;
    load          = 1'b0;
    take_in       = 1'b0;
    fifo_pop      = 1'b0;
    load_word     = fifo_rd_data;

    case (head_state_q)
      H_EMPTY: begin
        if (push) begin
          load    = 1'b1;
          take_in = 1'b1;
        end
      end
      H_PRESENT: begin
        if (xfer) begin
          if (fifo_rd_valid) begin
            load     = 1'b1;
            fifo_pop = 1'b1;
          end else if (push) begin
            load    = 1'b1;
            take_in = 1'b1;
          end else begin
            head_state_d  = H_EMPTY;
            order_valid_d = 1'b0;
          end
        end
      end
      H_STALL: begin
        if (rd_out_d != MAX_L) begin
          head_state_d  = H_PRESENT;
          order_valid_d = 1'b1;
        end
      end
      default: begin
        head_state_d  = H_EMPTY;
        order_valid_d = 1'b0;
      end
    endcase

    if (take_in) load_word = in_word;

    if (load) begin
      head_word_d = load_word;
      if ((load_word[OW-1 -: 2] == READ) && (rd_out_d == MAX_L)) begin
        head_state_d  = H_STALL;
        order_valid_d = 1'b0;
      end else begin
        head_state_d  = H_PRESENT;
        order_valid_d = 1'b1;
      end
    end

    fifo_push = push & ~take_in & ~fifo_wr_busy;
  end

  // Head FSM, output register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_state_q  <= H_EMPTY;
      order_valid_q <= 1'b0;
      head_word_q   <= '0;
      level_q       <= '0;
      rd_out_q      <= '0;
      in_busy_q     <= 1'b0;
    end else begin
      head_state_q  <= head_state_d;
      order_valid_q <= order_valid_d;
      head_word_q   <= head_word_d;
      level_q       <= level_d;
      rd_out_q      <= rd_out_d;
      in_busy_q     <= in_busy_d;
    end
  end

  assign in_busy     = in_busy_q;
  assign order_valid = order_valid_q;
  assign order_type  = head_word_q[OW-1 -: 2];
  assign order_table = head_word_q[ADDR_WIDTH+DATA_WIDTH +: TABLE_WIDTH];
  assign order_node  = head_word_q[DATA_WIDTH +: ADDR_WIDTH];
  assign order_data  = head_word_q[DATA_WIDTH-1:0];
  assign level       = level_q;
  assign rd_out      = rd_out_q;

`ifdef LINK_ORDER_STAT_EN
  logic [15:0] stat_appe_q, stat_appe_d;
  logic [15:0] stat_dele_q, stat_dele_d;
  logic [15:0] stat_chag_q, stat_chag_d;
  logic [15:0] stat_read_q, stat_read_d;

  // Saturating per-type count of orders handed to link_top.
  always_comb begin
    stat_appe_d = stat_appe_q;
    stat_dele_d = stat_dele_q;
    stat_chag_d = stat_chag_q;
    stat_read_d = stat_read_q;
    if (xfer) begin
      case (head_type)
        APPE:    if (stat_appe_q != 16'hFFFF) stat_appe_d = stat_appe_q + 16'd1;
        DELE:    if (stat_dele_q != 16'hFFFF) stat_dele_d = stat_dele_q + 16'd1;
        CHAG:    if (stat_chag_q != 16'hFFFF) stat_chag_d = stat_chag_q + 16'd1;
        default: if (stat_read_q != 16'hFFFF) stat_read_d = stat_read_q + 16'd1;
      endcase
    end
  end

  // Statistic registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_appe_q <= '0;
      stat_dele_q <= '0;
      stat_chag_q <= '0;
      stat_read_q <= '0;
    end else begin
      stat_appe_q <= stat_appe_d;
      stat_dele_q <= stat_dele_d;
      stat_chag_q <= stat_chag_d;
      stat_read_q <= stat_read_d;
    end
  end

  assign stat_appe = stat_appe_q;
  assign stat_dele = stat_dele_q;
  assign stat_chag = stat_chag_q;
  assign stat_read = stat_read_q;
`endif

endmodule
